// File: rtl/ov7670_pattern_gen_if.sv
// Camera-side bus of the OV7670 emulator: run controls going in, sensor
// timing and frame status coming out.
interface ov7670_pattern_gen_if;
    logic       enable;
    logic [1:0] pattern;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;
    logic       frame_done;
    logic [7:0] frame_cnt;

    // generator side
    modport master (
        input  enable, pattern,
        output vsync, href, px_data, frame_done, frame_cnt
    );

    // capture / controller side
    modport slave (
        output enable, pattern,
        input  vsync, href, px_data, frame_done, frame_cnt
    );
endinterface

// File: rtl/ov7670_pattern_gen.sv
// OV7670 sensor emulator: produces vsync/href/px_data with RGB565 two-bytes-
// per-pixel timing and selectable test patterns. The counters describe the
// cycle currently on the outputs. Each edge computes the next cycle's position
// and registers the outputs decoded from it, so every output is a flop.
module ov7670_pattern_gen #(
    parameter int          H_PIX       = 160,
    parameter int          V_LINES     = 120,
    parameter int          H_BLANK     = 16,
    parameter int          VSYNC_CYC   = 64,
    parameter int          VBP_CYC     = 32,
    parameter int          VFP_CYC     = 32,
    parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
    input  logic           pclk,
    input  logic           rst,
    ov7670_pattern_gen_if.master cam
);

    localparam int CW = 16;
    localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_CYC - 1);
    localparam logic [CW-1:0] VBP_LAST = CW'(VBP_CYC - 1);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VFP_LAST = CW'(VFP_CYC - 1);
    localparam logic [8:0]    COL_LAST = 9'(H_PIX - 1);
    localparam logic [7:0]    ROW_LAST = 8'(V_LINES - 1);
    localparam logic [8:0]    BAR_LAST = 9'(H_PIX / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_HBLANK,
        S_VFP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;        // cycles spent in timed states
    logic [8:0]    col_q, col_d;
    logic [7:0]    row_q, row_d;
    logic          ph_q, ph_d;          // 0 = high byte, 1 = low byte
    logic [2:0]    bar_q, bar_d;        // colour-bar index
    logic [8:0]    barcnt_q, barcnt_d;  // pixels into current bar
    logic [1:0]    pat_q, pat_d;        // pattern frozen for the frame
    logic [7:0]    fcnt_q, fcnt_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          done_q, done_d;
    logic [7:0]    px_q, px_d;
    logic [15:0]   pix;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Next position in the frame: state, timing counter, pixel coordinates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        col_d    = col_q;
        row_d    = row_q;
        ph_d     = ph_q;
        bar_d    = bar_q;
        barcnt_d = barcnt_q;
        pat_d    = pat_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cam.enable) begin
                    state_d = S_VSYNC;
                    pat_d   = cam.pattern;
                end
            end
            S_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = S_VBP;
                    cnt_d   = '0;
                end
            end
            S_VBP: begin
                if (cnt_q == VBP_LAST) begin
                    state_d  = S_ACTIVE;
                    cnt_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                    ph_d     = 1'b0;
                    bar_d    = '0;
                    barcnt_d = '0;
                end
            end
            S_ACTIVE: begin
                cnt_d = '0;
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else if (col_q == COL_LAST) begin
                    ph_d    = 1'b0;
                    state_d = (row_q == ROW_LAST) ? S_VFP : S_HBLANK;
                end else begin
                    ph_d  = 1'b0;
                    col_d = col_q + 9'd1;
                    // bar index advances by width counting, no divider needed
                    if (barcnt_q == BAR_LAST) begin
                        barcnt_d = '0;
                        bar_d    = bar_q + 3'd1;
                    end else begin
                        barcnt_d = barcnt_q + 9'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d  = S_ACTIVE;
                    cnt_d    = '0;
                    row_d    = row_q + 8'd1;
                    col_d    = '0;
                    ph_d     = 1'b0;
                    bar_d    = '0;
                    barcnt_d = '0;
                end
            end
            S_VFP: begin
                if (cnt_q == VFP_LAST) begin
                    cnt_d = '0;
                    if (cam.enable) begin
                        state_d = S_VSYNC;
                        pat_d   = cam.pattern;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pixel colour at the next output position.
    always_comb begin
        pix = SOLID_COLOR;
        case (pat_d)
            2'd0:    pix = bar_color(bar_d);
            2'd1:    pix = {col_d[4:0], row_d[5:0], 5'b0};
            2'd2:    pix = (col_d[3] ^ row_d[3]) ? 16'hFFFF : 16'h0000;
            default: pix = SOLID_COLOR;
        endcase
    end

    // Output decode of the next position; frame_done marks the last VFP cycle.
    always_comb begin
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE);
        px_d    = 8'h00;
        if (href_d) begin
            px_d = ph_d ? pix[7:0] : pix[15:8];
        end
        done_d = (state_d == S_VFP) && (cnt_d == VFP_LAST);
        fcnt_d = done_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    // State and output registers; reset wins over any frame position.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ph_q     <= 1'b0;
            bar_q    <= '0;
            barcnt_q <= '0;
            pat_q    <= '0;
            fcnt_q   <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            done_q   <= 1'b0;
            px_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ph_q     <= ph_d;
            bar_q    <= bar_d;
            barcnt_q <= barcnt_d;
            pat_q    <= pat_d;
            fcnt_q   <= fcnt_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            done_q   <= done_d;
            px_q     <= px_d;
        end
    end

    assign cam.vsync      = vsync_q;
    assign cam.href       = href_q;
    assign cam.px_data    = px_q;
    assign cam.frame_done = done_q;
    assign cam.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_ov7670_pattern_gen.sv
// Bench for ov7670_pattern_gen: three instances (default, mid and tiny
// geometry) each checked every cycle against a frame-timeline reference,
// plus directed timing/pixel checks and randomized enable/pattern/reset.
module tb_ov7670_pattern_gen;

    logic pclk;
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    logic       rst0, rst1, rst2, en0, en1, en2;
    logic [1:0] pat0, pat1, pat2;
    logic       vs_w [3];
    logic       hr_w [3];
    logic       dn_w [3];
    logic [7:0] px_w [3];
    logic [7:0] fc_w [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // RGB565 value of pixel (col,row) straight from the pattern definitions
    function automatic logic [15:0] ref_pix(input int pat, input int col, input int row,
                                            input int hp, input logic [15:0] solid);
        logic [15:0] c16, r16;
        c16 = 16'(col);
        r16 = 16'(row);
        case (pat)
            0: begin
                case (col / (hp / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1: return {c16[4:0], r16[5:0], 5'b0};
            2: return (c16[3] ^ r16[3]) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    // Expected {vsync, href, frame_done, px_data} at cycle t of a frame (t<0: idle)
    function automatic logic [10:0] exp_out(input int t, input int pat, input int hp, input int vl,
                                            input int hb, input int vs, input int vbp, input int vfp,
                                            input logic [15:0] solid);
        int u, l, a, row, r;
        logic [15:0] p;
        if (t < 0) return '0;
        if (t < vs) return 11'h400;
        if (t < vs + vbp) return '0;
        u = t - vs - vbp;
        l = 2 * hp + hb;
        a = vl * 2 * hp + (vl - 1) * hb;
        if (u >= a) return {2'b00, (u - a == vfp - 1), 8'h00};
        row = u / l;
        r   = u % l;
        if (r >= 2 * hp) return '0;
        p = ref_pix(pat, r / 2, row, hp, solid);
        return {2'b01, 1'b0, (r % 2 == 0) ? p[15:8] : p[7:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int HP  = (g == 0) ? 160 : (g == 1) ? 16 : 8;
        localparam int VL  = (g == 0) ? 120 : (g == 1) ? 10 : 2;
        localparam int HB  = (g == 0) ? 16  : (g == 1) ? 2  : 1;
        localparam int VS  = (g == 0) ? 64  : (g == 1) ? 3  : 1;
        localparam int VBP = (g == 0) ? 32  : (g == 1) ? 2  : 1;
        localparam int VFP = (g == 0) ? 32  : (g == 1) ? 2  : 1;
        localparam logic [15:0] SOL = (g == 2) ? 16'h5A3C : 16'hF800;
        localparam int FL  = VS + VBP + VL * 2 * HP + (VL - 1) * HB + VFP;

        ov7670_pattern_gen_if bus();
        logic        rst_g;
        int          t;
        int          mpat;
        logic [7:0]  mfc;
        logic [10:0] e;
        string       pfx;

        initial pfx = $sformatf("i%0d.", g);

        assign rst_g       = (g == 0) ? rst0 : (g == 1) ? rst1 : rst2;
        assign bus.enable  = (g == 0) ? en0  : (g == 1) ? en1  : en2;
        assign bus.pattern = (g == 0) ? pat0 : (g == 1) ? pat1 : pat2;
        assign vs_w[g] = bus.vsync;
        assign hr_w[g] = bus.href;
        assign dn_w[g] = bus.frame_done;
        assign px_w[g] = bus.px_data;
        assign fc_w[g] = bus.frame_cnt;

        ov7670_pattern_gen #(
            .H_PIX(HP), .V_LINES(VL), .H_BLANK(HB), .VSYNC_CYC(VS),
            .VBP_CYC(VBP), .VFP_CYC(VFP), .SOLID_COLOR(SOL)
        ) dut (
            .pclk (pclk),
            .rst  (rst_g),
            .cam  (bus)
        );

        // frame-position model: frames start the cycle after enable is seen
        always @(posedge pclk) begin
            if (rst_g) begin
                t   <= -1;
                mfc <= 8'd0;
            end else if (t < 0) begin
                if (bus.enable) begin
                    t    <= 0;
                    mpat <= int'(bus.pattern);
                end
            end else if (t == FL - 1) begin
                if (bus.enable) begin
                    t    <= 0;
                    mpat <= int'(bus.pattern);
                end else begin
                    t <= -1;
                end
            end else begin
                t <= t + 1;
                if (t + 1 == FL - 1) mfc <= mfc + 8'd1;
            end
        end

        always @(negedge pclk) begin
            if (chk_on) begin
                e = exp_out(t, mpat, HP, VL, HB, VS, VBP, VFP, SOL);
                chk({pfx, "vsync"},   32'(bus.vsync),      32'(e[10]));
                chk({pfx, "href"},    32'(bus.href),       32'(e[9]));
                chk({pfx, "done"},    32'(bus.frame_done), 32'(e[8]));
                chk({pfx, "px"},      32'(bus.px_data),    32'(e[7:0]));
                chk({pfx, "fcnt"},    32'(bus.frame_cnt),  32'(mfc));
            end
        end
    end

    task automatic wait_done(input int g, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge pclk);
            if (dn_w[g]) ok = 1;
        end
    endtask

    // Default geometry: full-frame timing, pattern-0 bytes, late enable drop,
    // then reset in the middle of a line.
    task automatic run_i0();
        int n, vs_hi, hrise, bad_len, bad_gap, first_vs_low, first_href, done_idx, hlen, glen, nv;
        logic v, h, pv, ph;
        logic [7:0] row0 [320];
        logic [7:0] row60 [320];
        bit ok;
        vs_hi = 0; hrise = 0; bad_len = 0; bad_gap = 0; hlen = 0; glen = 0;
        first_vs_low = -1; first_href = -1; done_idx = -1; pv = 0; ph = 0;
        repeat (100) @(posedge pclk);
        #1 en0 = 1'b1; pat0 = 2'd0;
        @(posedge pclk);
        for (n = 0; n < 41000 && done_idx < 0; n++) begin
            @(negedge pclk);
            v = vs_w[0];
            h = hr_w[0];
            if (v) vs_hi++;
            if (!v && pv && first_vs_low < 0) first_vs_low = n;
            if (h && !ph) begin
                hrise++;
                if (first_href < 0) first_href = n;
                if (hrise > 1 && glen != 16) bad_gap++;
                hlen = 0;
            end
            if (!h && ph) begin
                if (hlen != 320) bad_len++;
                glen = 0;
            end
            if (h) begin
                if (hlen < 320 && hrise == 1)  row0[hlen] = px_w[0];
                if (hlen < 320 && hrise == 61) row60[hlen] = px_w[0];
                hlen++;
            end else begin
                glen++;
            end
            if (dn_w[0]) done_idx = n;
            // start of line 50: stop after this frame and try to change pattern
            if (n == 64 + 32 + 50 * 336) begin
                en0  = 1'b0;
                pat0 = 2'd3;
            end
            pv = v;
            ph = h;
        end
        chk("i0.vsync_len",   32'(vs_hi), 32'd64);
        chk("i0.vbp_len",     32'(first_href - first_vs_low), 32'd32);
        chk("i0.href_pulses", 32'(hrise), 32'd120);
        chk("i0.href_badlen", 32'(bad_len), 32'd0);
        chk("i0.hblank_bad",  32'(bad_gap), 32'd0);
        chk("i0.done_cycle",  32'(done_idx), 32'd40431);
        chk("i0.fcnt_1",      32'(fc_w[0]), 32'd1);
        chk("i0.pix0",   {16'h0, row0[0],   row0[1]},   32'hFFFF);
        chk("i0.pix20",  {16'h0, row0[40],  row0[41]},  32'hFFE0);
        chk("i0.pix100", {16'h0, row0[200], row0[201]}, 32'hF800);
        chk("i0.pix159", {16'h0, row0[318], row0[319]}, 32'h0000);
        chk("i0.r60_pix100", {16'h0, row60[200], row60[201]}, 32'hF800);
        nv = 0;
        repeat (200) begin
            @(negedge pclk);
            if (vs_w[0]) nv++;
        end
        chk("i0.idle_no_vsync", 32'(nv), 32'd0);
        chk("i0.idle_fcnt",     32'(fc_w[0]), 32'd1);
        // reset mid-line
        en0 = 1'b1; pat0 = 2'd2;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge pclk);
            if (hr_w[0]) ok = 1;
        end
        chk("i0.href_seen", 32'(ok), 32'd1);
        repeat (37) @(negedge pclk);
        rst0 = 1'b1; en0 = 1'b0;
        @(posedge pclk);
        #1 rst0 = 1'b0;
        @(negedge pclk);
        chk("i0.rst_href", 32'(hr_w[0]), 32'd0);
        chk("i0.rst_px",   32'(px_w[0]), 32'd0);
        chk("i0.rst_fcnt", 32'(fc_w[0]), 32'd0);
        repeat (20) @(negedge pclk);
    endtask

    // Mid geometry: solid then checkerboard frame, then random traffic.
    task automatic run_i1();
        bit ok;
        @(posedge pclk);
        #1 en1 = 1'b1; pat1 = 2'd3;
        wait_done(1, 500, ok);
        chk("i1.done_solid", 32'(ok), 32'd1);
        pat1 = 2'd2;   // relatched on the edge that closes this frame
        wait_done(1, 500, ok);
        chk("i1.done_checker", 32'(ok), 32'd1);
        for (int f = 0; f < 16; f++) begin
            @(posedge pclk);
            #1;
            en1  = ($urandom_range(0, 4) != 0);
            pat1 = 2'($urandom_range(0, 3));
            repeat ($urandom_range(30, 600)) @(posedge pclk);
            if ($urandom_range(0, 5) == 0) begin
                #1 rst1 = 1'b1;
                @(posedge pclk);
                #1 rst1 = 1'b0;
            end
        end
        en1 = 1'b0;
        repeat (400) @(posedge pclk);
    endtask

    // Tiny geometry: reset mid-line, restart, run 256 frames to wrap frame_cnt.
    task automatic run_i2();
        bit ok;
        int frames;
        @(posedge pclk);
        #1 en2 = 1'b1; pat2 = 2'd1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge pclk);
            if (hr_w[2]) ok = 1;
        end
        chk("i2.href_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge pclk);
        rst2 = 1'b1;
        @(posedge pclk);
        #1 rst2 = 1'b0;
        @(negedge pclk);
        chk("i2.rst_href", 32'(hr_w[2]), 32'd0);
        chk("i2.rst_px",   32'(px_w[2]), 32'd0);
        chk("i2.rst_fcnt", 32'(fc_w[2]), 32'd0);
        frames = 0;
        for (int i = 0; i < 256 * 36 + 200 && frames < 256; i++) begin
            @(negedge pclk);
            if (dn_w[2]) begin
                frames++;
                if (frames == 255) chk("i2.fcnt_255", 32'(fc_w[2]), 32'd255);
                pat2 = 2'($urandom_range(0, 3));
            end
        end
        chk("i2.frames", 32'(frames), 32'd256);
        chk("i2.wrap",   32'(fc_w[2]), 32'd0);
        en2 = 1'b0;
        repeat (50) @(posedge pclk);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        pat0 = 2'd0; pat1 = 2'd0; pat2 = 2'd0;
        repeat (3) @(posedge pclk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        chk_on = 1;
        fork
            run_i0();
            run_i1();
            run_i2();
        join
        repeat (5) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_pattern_gen.md
Name: ov7670_pattern_gen

Overview:
Synthesizable OV7670 sensor emulator for simulation and board bring-up. It runs on the camera pixel clock and drives vsync, href and px_data with the sensor's RGB565 two-bytes-per-pixel timing. The capture block downstream consumes these signals unchanged, so capture and frame-buffer paths can be verified without a physical camera. It generates selectable test patterns and reports frame completion.

Parameters:
H_PIX, 160, active pixels per line (multiple of 8, ≤ 320)
V_LINES, 120, active lines per frame (≤ 240)
H_BLANK, 16, href-low pclk cycles between lines (≥ 1)
VSYNC_CYC, 64, pclk cycles vsync held high
VBP_CYC, 32, pclk cycles from vsync fall to first href rise
VFP_CYC, 32, pclk cycles after last line before next vsync or idle
SOLID_COLOR, 16'hF800, RGB565 value used by pattern 3

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  synchronous active-high reset
enable  in  1  run frames while high
pattern  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 solid
vsync  out  1  frame sync, active high
href  out  1  line valid, active high
px_data  out  8  pixel byte; high byte first
frame_done  out  1  one-cycle pulse at end of each frame
frame_cnt  out  8  completed-frame counter, wraps 255→0

Behaviour:
- Reset (rst=1 at an edge): state IDLE, vsync=0, href=0, px_data=0, frame_done=0, frame_cnt=0, col/row/byte counters=0. Reset overrides any state, including mid-line.
- All outputs are registered. The first output change follows the sampling edge by one cycle.
- FSM states: IDLE → VSYNC → VBP → ACTIVE ⇄ HBLANK → VFP → VSYNC or IDLE.
- IDLE: all outputs low. When enable=1 is sampled, go to VSYNC and latch pattern into pat_q. pat_q holds for the whole frame, so pattern changes mid-frame have no effect.
- VSYNC: vsync=1 for exactly VSYNC_CYC cycles, then VBP.
- VBP: vsync=0, href=0 for exactly VBP_CYC cycles, then ACTIVE with row=0.
- ACTIVE: href=1 for exactly 2*H_PIX cycles.
  - Byte phase toggles each cycle, starting at 0.
  - Phase 0: px_data = P[15:8] = {R[4:0],G[5:3]}. Phase 1: px_data = P[7:0] = {G[2:0],B[4:0]}.
  - col increments after phase 1.
- After the last byte of a line: if row < V_LINES-1, go to HBLANK (href=0, px_data=0) for exactly H_BLANK cycles, then row++ and return to ACTIVE. If row = V_LINES-1, go to VFP.
- VFP: outputs low for VFP_CYC cycles. On the last VFP cycle, frame_done=1 and frame_cnt increments on that edge (mod 256). Next state is VSYNC if enable=1 (relatch pattern), else IDLE.
- enable deasserted mid-frame: the current frame completes fully, including frame_done; then IDLE.
- px_data is 0 whenever href=0.
- Pattern P (RGB565) per pixel at (col,row):
  - 0: 8 vertical bars, each H_PIX/8 wide. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a bar-width counter, not a divider.
  - 1: P = {col[4:0], row[5:0], 5'b0}.
  - 2: P = (col[3]^row[3]) ? FFFF : 0000 (8x8 checkerboard).
  - 3: P = SOLID_COLOR.
- Frame length: VSYNC_CYC + VBP_CYC + V_LINES*2*H_PIX + (V_LINES-1)*H_BLANK + VFP_CYC pclk cycles. With defaults this is 40432.

Test Plan:
1. Reset then hold enable=0 for 100 cycles → vsync, href, px_data, frame_done and frame_cnt all 0.
2. Defaults, enable=1, pattern=0:
   - vsync high exactly 64 cycles; first href rise 32 cycles after vsync fall.
   - 120 href pulses, each 320 cycles, separated by 16 low cycles.
   - frame_done pulse at cycle 40432 after enable sampled; frame_cnt=1.
3. Pattern 0 byte check:
   - pixel 0 → FF,FF; pixel 20 → FF,E0; pixel 100 → F8,00; pixel 159 → 00,00.
   - Sample only while href=1.
4. Pattern 2, row 0: pixels 0–7 → 00,00 and pixels 8–15 → FF,FF. Row 8 inverts this. Pattern 3 → F8,00 on every pixel.
5. Drop enable at line 50 and switch pattern to 3 mid-frame:
   - Frame finishes with pattern 0 data.
   - frame_done pulses, then IDLE; no further vsync.
6. Assert rst for one cycle mid-line (href=1):
   - Next cycle href=0, px_data=0, frame_cnt=0.
   - Restart with enable=1 produces a full, correct frame. frame_cnt wraps 255→0 after 256 frames (short-parameter run).
